// File: rtl/adder_subtractor_checker.sv
// ---------------------------------------------------------------------------
// adder_subtractor_checker
//
// Response checker for a ripple-carry adder/subtractor. Each accepted tuple
// (a, b, subtract, dut_out, dut_cout) is compared against an internally
// computed golden result. Passes and failures are counted over a programmed
// run length, and the first failing tuple of a run is captured for readout.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, num_vectors    begin a run of num_vectors tuples (clears scores)
//   in_valid, a, b,       tuple sampled this cycle when in_valid is high
//   subtract, dut_out,
//   dut_cout
//   busy / done           run in progress / run finished (held until start)
//   all_pass              done with zero failures
//   pass_count,           saturating per-run score counters
//   fail_count
//   first_fail_*          first mismatching tuple of the run
//   dbg_state             FSM state: 0 = IDLE, 1 = RUN, 2 = DONE
//
// Handshake: a tuple is taken on a rising edge where in_valid is high, the
// checker is in RUN, start is low and fewer than num_vectors tuples have
// been taken; there is no back-pressure, so any other tuple is dropped.
// ---------------------------------------------------------------------------
module adder_subtractor_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    input  logic [WIDTH-1:0] dut_out,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic             first_fail_sub,
    output logic [WIDTH-1:0] first_fail_out,
    output logic             first_fail_cout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;
    logic [CNT_W-1:0] scored_q, scored_d;
    logic [CNT_W-1:0] pass_count_q, pass_count_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;

    // Stage 1: registered tuple plus its compare result
    logic             s1_valid_q, s1_valid_d;
    logic             s1_pass_q, s1_pass_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_sub_q, s1_sub_d;
    logic [WIDTH-1:0] s1_out_q, s1_out_d;
    logic             s1_cout_q, s1_cout_d;

    // First-fail capture
    logic             ff_valid_q, ff_valid_d;
    logic [WIDTH-1:0] ff_a_q, ff_a_d;
    logic [WIDTH-1:0] ff_b_q, ff_b_d;
    logic             ff_sub_q, ff_sub_d;
    logic [WIDTH-1:0] ff_out_q, ff_out_d;
    logic             ff_cout_q, ff_cout_d;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   gold_sum;
    logic             in_match;
    logic             accept;
    logic [CNT_W-1:0] scored_inc;

    // Subtraction as A + ~B + 1; the carry out doubles as "no borrow".
    assign b_eff    = b ^ {WIDTH{subtract}};
    assign gold_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};
    assign in_match = (dut_out == gold_sum[WIDTH-1:0]) && (dut_cout == gold_sum[WIDTH]);

    assign accept     = (state_q == ST_RUN) && in_valid && !start && (accepted_q < target_q);
    assign scored_inc = scored_q + CNT_ONE;

    // Next-state logic. Completion keys off the tuple being scored in
    // stage 2, so done lines up with the final counter update.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (num_vectors == '0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_RUN && s1_valid_q && scored_inc == target_q) begin
            state_d = ST_DONE;
        end
    end

    always_comb begin
        target_d     = target_q;
        accepted_d   = accepted_q;
        scored_d     = scored_q;
        pass_count_d = pass_count_q;
        fail_count_d = fail_count_q;

        s1_valid_d = accept;
        s1_pass_d  = accept ? in_match : s1_pass_q;
        s1_a_d     = accept ? a        : s1_a_q;
        s1_b_d     = accept ? b        : s1_b_q;
        s1_sub_d   = accept ? subtract : s1_sub_q;
        s1_out_d   = accept ? dut_out  : s1_out_q;
        s1_cout_d  = accept ? dut_cout : s1_cout_q;

        ff_valid_d = ff_valid_q;
        ff_a_d     = ff_a_q;
        ff_b_d     = ff_b_q;
        ff_sub_d   = ff_sub_q;
        ff_out_d   = ff_out_q;
        ff_cout_d  = ff_cout_q;

        if (start) begin
            // A restart also drops whatever sits in stage 1.
            target_d     = num_vectors;
            accepted_d   = '0;
            scored_d     = '0;
            pass_count_d = '0;
            fail_count_d = '0;
            s1_valid_d   = 1'b0;
            ff_valid_d   = 1'b0;
            ff_a_d       = '0;
            ff_b_d       = '0;
            ff_sub_d     = 1'b0;
            ff_out_d     = '0;
            ff_cout_d    = 1'b0;
        end else begin
            if (accept) begin
                accepted_d = accepted_q + CNT_ONE;
            end
            if (s1_valid_q) begin
                scored_d = scored_inc;
                if (s1_pass_q) begin
                    if (pass_count_q != CNT_MAX) pass_count_d = pass_count_q + CNT_ONE;
                end else begin
                    if (fail_count_q != CNT_MAX) fail_count_d = fail_count_q + CNT_ONE;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_a_d     = s1_a_q;
                        ff_b_d     = s1_b_q;
                        ff_sub_d   = s1_sub_q;
                        ff_out_d   = s1_out_q;
                        ff_cout_d  = s1_cout_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            accepted_q   <= '0;
            scored_q     <= '0;
            pass_count_q <= '0;
            fail_count_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_pass_q    <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_sub_q     <= 1'b0;
            s1_out_q     <= '0;
            s1_cout_q    <= 1'b0;
            ff_valid_q   <= 1'b0;
            ff_a_q       <= '0;
            ff_b_q       <= '0;
            ff_sub_q     <= 1'b0;
            ff_out_q     <= '0;
            ff_cout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            accepted_q   <= accepted_d;
            scored_q     <= scored_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
            s1_valid_q   <= s1_valid_d;
            s1_pass_q    <= s1_pass_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_sub_q     <= s1_sub_d;
            s1_out_q     <= s1_out_d;
            s1_cout_q    <= s1_cout_d;
            ff_valid_q   <= ff_valid_d;
            ff_a_q       <= ff_a_d;
            ff_b_q       <= ff_b_d;
            ff_sub_q     <= ff_sub_d;
            ff_out_q     <= ff_out_d;
            ff_cout_q    <= ff_cout_d;
        end
    end

    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign all_pass         = (state_q == ST_DONE) && (fail_count_q == '0);
    assign pass_count       = pass_count_q;
    assign fail_count       = fail_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_a     = ff_a_q;
    assign first_fail_b     = ff_b_q;
    assign first_fail_sub   = ff_sub_q;
    assign first_fail_out   = ff_out_q;
    assign first_fail_cout  = ff_cout_q;
    assign dbg_state        = state_q;

endmodule
